// File: rtl/ad_par_pkg.sv
// Shared types for the parallel-ADC read controller: FSM states, error bit
// positions and a counter sizing helper.
package ad_par_pkg;

    typedef enum logic [2:0] {
        RSTP,
        IDLE,
        CONV,
        WBH,
        WBL,
        RDLO,
        RDHI,
        OUT
    } state_e;

    localparam int unsigned ERR_W    = 3;
    localparam int unsigned ERR_TO   = 0;
    localparam int unsigned ERR_FRST = 1;
    localparam int unsigned ERR_OVR  = 2;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter only has to hold (longest interval - 1).
    function automatic int unsigned cnt_bits(input int unsigned max_count);
        return (max_count > 2) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ad_sync2.sv
// Two-flop synchronizer for single-bit asynchronous ADC status inputs.
module ad_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ad_par_ctrl.sv
// Parallel-interface ADC controller: issues convst, waits on busy, then reads
// NCH channels with rd_n strobes and hands each sample out on a valid/ready port.
module ad_par_ctrl
    import ad_par_pkg::*;
#(
    parameter int unsigned NCH     = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned T_CONV  = 2,
    parameter int unsigned T_RD_LO = 3,
    parameter int unsigned T_RD_HI = 2,
    parameter int unsigned T_TO    = 20000,
    parameter int unsigned T_RST   = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic                                   cont_i,
    input  logic [2:0]                             os_i,
    output logic [2:0]                             adc_os_o,
    output logic                                   adc_reset_o,
    output logic                                   adc_convst_o,
    output logic                                   adc_cs_n_o,
    output logic                                   adc_rd_n_o,
    input  logic                                   adc_busy_i,
    input  logic                                   adc_frstdata_i,
    input  logic [DW-1:0]                          adc_db_i,
    output logic [DW-1:0]                          sample_o,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] chan_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   active_o,
    output logic [2:0]                             err_o
);

    localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNT_MAX = max2(max2(max2(T_CONV, T_RD_LO), max2(T_RD_HI, T_TO)), T_RST);
    localparam int unsigned CW      = cnt_bits(CNT_MAX);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHW-1:0]   chan_q, chan_d;
    logic [CHW-1:0]   chan_out_q, chan_out_d;
    logic [DW-1:0]    sample_q, sample_d;
    logic [2:0]       os_q, os_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic reset_pin_q, reset_pin_d;
    logic convst_q, convst_d;
    logic cs_n_q, cs_n_d;
    logic rd_n_q, rd_n_d;
    logic valid_q, valid_d;
    logic active_q, active_d;

    logic busy_s;
    logic frst_s;

    ad_sync2 u_sync_busy (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (adc_busy_i),
        .q_o     (busy_s)
    );

    ad_sync2 u_sync_frst (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (adc_frstdata_i),
        .q_o     (frst_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        chan_d     = chan_q;
        chan_out_d = chan_out_q;
        sample_d   = sample_q;
        os_d       = os_q;
        err_d      = err_q;

        if (start_i && active_q) begin
            err_d[ERR_OVR] = 1'b1;
        end

        unique case (state_q)
            RSTP: begin
                if (cnt_q == CW'(T_RST - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (start_i || cont_i) begin
                    state_d = CONV;
                    os_d    = os_i;
                end
            end
            CONV: begin
                if (cnt_q == CW'(T_CONV - 1)) begin
                    state_d = WBH;
                    cnt_d   = '0;
                end
            end
            // The timeout counter runs across both busy-wait states without restarting.
            WBH, WBL: begin
                if (cnt_q == CW'(T_TO - 1)) begin
                    err_d[ERR_TO] = 1'b1;
                    state_d       = IDLE;
                end else if (state_q == WBH && busy_s) begin
                    state_d = WBL;
                end else if (state_q == WBL && !busy_s) begin
                    state_d = RDLO;
                    cnt_d   = '0;
                    chan_d  = '0;
                end
            end
            RDLO: begin
                if (cnt_q == CW'(T_RD_LO - 1)) begin
                    sample_d   = adc_db_i;
                    chan_out_d = chan_q;
                    if (frst_s != (chan_q == '0)) begin
                        err_d[ERR_FRST] = 1'b1;
                    end
                    state_d = OUT;
                    cnt_d   = '0;
                end
            end
            OUT: begin
                cnt_d = '0;
                if (ready_i) begin
                    if (chan_q == CHW'(NCH - 1)) begin
                        state_d = IDLE;
                    end else begin
                        chan_d  = CHW'(chan_q + 1'b1);
                        state_d = RDHI;
                    end
                end
            end
            RDHI: begin
                if (cnt_q == CW'(T_RD_HI - 1)) begin
                    state_d = RDLO;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RSTP;
                cnt_d   = '0;
            end
        endcase

        // Pins are decoded from the next state so they come straight off flops.
        reset_pin_d = (state_d == RSTP);
        convst_d    = (state_d != CONV);
        cs_n_d      = !(state_d inside {RDLO, OUT, RDHI});
        rd_n_d      = (state_d != RDLO);
        valid_d     = (state_d == OUT);
        active_d    = !(state_d inside {IDLE, RSTP});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RSTP;
            cnt_q       <= '0;
            chan_q      <= '0;
            chan_out_q  <= '0;
            sample_q    <= '0;
            os_q        <= '0;
            err_q       <= '0;
            reset_pin_q <= 1'b1;
            convst_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            chan_out_q  <= chan_out_d;
            sample_q    <= sample_d;
            os_q        <= os_d;
            err_q       <= err_d;
            reset_pin_q <= reset_pin_d;
            convst_q    <= convst_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
        end
    end

    assign adc_os_o     = os_q;
    assign adc_reset_o  = reset_pin_q;
    assign adc_convst_o = convst_q;
    assign adc_cs_n_o   = cs_n_q;
    assign adc_rd_n_o   = rd_n_q;
    assign sample_o     = sample_q;
    assign chan_o       = chan_out_q;
    assign valid_o      = valid_q;
    assign active_o     = active_q;
    assign err_o        = err_q;

endmodule

// File: doc/ad_par_ctrl.md
AD_PAR_CTRL -- requirements
Module: ad_par_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  NCH 8 channels read per conversion, 1..16
  DW 16 sample width
  T_CONV 2 convst low-pulse width, clk cycles
  T_RD_LO 3 rd_n low width; sample captured on last low cycle
  T_RD_HI 2 rd_n high width between reads
  T_TO 20000 busy timeout, cycles
  T_RST 4 adc_reset_o pulse width after reset_i release
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_i in 1 system clock
  reset_i in 1 reset, asynchronous, active-high
  start_i in 1 single-cycle conversion request
  cont_i in 1 continuous mode: restart after each frame
  os_i in 3 oversampling select, registered to adc_os_o in IDLE only
  adc_os_o out 3 ADC OS pins
  adc_reset_o out 1 ADC reset pin
  adc_convst_o out 1 ADC convst (idle high; rising edge starts conversion)
  adc_cs_n_o out 1 ADC chip select
  adc_rd_n_o out 1 ADC read strobe
  adc_busy_i in 1 ADC busy (asynchronous)
  adc_frstdata_i in 1 ADC first-data flag (asynchronous)
  adc_db_i in DW ADC data bus
  sample_o out DW captured sample
  chan_o out max(1,$clog2(NCH)) channel index of sample_o
  valid_o out 1 sample_o/chan_o valid
  ready_i in 1 consumer accepts when valid_o&&ready_i
  active_o out 1 high in any state except IDLE/RSTP
  err_o out 3 sticky: [0] busy timeout, [1] frstdata mismatch, [2] overrun

Function
REQ-003 adc_busy_i and adc_frstdata_i SHALL pass a 2-flop synchronizer before use; adc_db_i SHALL be sampled directly.
REQ-004 FSM states SHALL be RSTP, IDLE, CONV, WBH, WBL, RDLO, RDHI, OUT.
REQ-005 RSTP: adc_reset_o high T_RST cycles after reset_i release, then IDLE.
REQ-006 IDLE: on start_i or cont_i -> CONV; adc_os_o<=os_i that cycle.
REQ-007 CONV: adc_convst_o low exactly T_CONV cycles, then high -> WBH.
REQ-008 WBH: wait synced busy=1 -> WBL; WBL: wait synced busy=0 -> RDLO with chan=0, adc_cs_n_o low.
REQ-009 Cycle counter in WBH+WBL SHALL hit T_TO -> set err_o[0], drive cs_n/rd_n high, -> IDLE.
REQ-010 RDLO: adc_rd_n_o low T_RD_LO cycles; last cycle latches adc_db_i into sample_o, chan into chan_o, -> OUT.
REQ-011 OUT: valid_o high, rd_n high; hold sample_o/chan_o stable until ready_i; on accept chan==NCH-1 -> IDLE (cs_n high) else chan+1 -> RDHI.
REQ-012 RDHI: rd_n high T_RD_HI cycles -> RDLO; backpressure never drops samples, only stretches rd_n high.
REQ-013 Synced frstdata sampled with data SHALL equal (chan==0); mismatch sets err_o[1]; sample still delivered.
REQ-014 start_i while active_o=1 SHALL set err_o[2] and be otherwise ignored.
REQ-015 Continuous mode: from IDLE, next CONV starts on the cycle after the last accept; clearing cont_i stops after current frame.
REQ-016 err_o bits SHALL clear only on reset_i.

Reset
REQ-017 reset_i high SHALL immediately force: state RSTP, adc_reset_o 1, adc_convst_o 1, adc_cs_n_o 1, adc_rd_n_o 1, valid_o 0, sample_o 0, chan_o 0, adc_os_o 0, err_o 0, active_o 0, counters 0, synchronizers 0.

Structure
REQ-018 Package ad_par_pkg SHALL hold the state enumeration and err_o bit indices.
REQ-019 Synchronizer SHALL be sub-module ad_sync2, instanced twice.

Verification (NCH=8, T_CONV=2, T_RD_LO=3, T_RD_HI=2, T_TO=1000, ready_i=1 unless stated)
REQ-020 start_i, model busy 1 for 50 cycles -> convst low 2 cycles, 8 valid beats chan 0..7 matching bus values, cs_n low only during frame.
REQ-021 ready_i low 10 cycles at chan 3 -> sample_o/chan_o stable, rd_n high, no loss; chan 4..7 follow.
REQ-022 busy never rises -> err_o=3'b001 after 1000 cycles, IDLE, cs_n=1, no valid_o.
REQ-023 frstdata high at chan 2 -> err_o[1]=1, all 8 samples delivered.
REQ-024 start_i mid-frame -> err_o[2]=1, frame unaffected; cont_i=1 -> back-to-back frames, gap 1 cycle.
REQ-025 reset_i asserted during RDLO chan 4 -> all outputs at REQ-017 values same cycle; adc_reset_o 4 cycles after release.
